ext_imm_pipe: RTL and testbench



---
 rtl/ext_pkg.sv | 24 ++
 rtl/ext_stage.sv | 28 ++
 rtl/ext_imm_pipe.sv | 136 +++++++++++++
 tb/tb_ext_imm_pipe.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the pipelined ARM immediate extender: ImmSrc encodings,
// rotate-field position and the 32-bit rotate helper.
package ext_pkg;

    localparam int IMM_W   = 32;
    localparam int ROT_LSB = 8;
    localparam int ROT_MSB = 11;
    localparam int ROT_W   = ROT_MSB - ROT_LSB + 1;

    typedef enum logic [2:0] {
        DP_IMM8 = 3'b000,
        DP_ROT  = 3'b001,
        MEM12   = 3'b010,
        MEM_H8  = 3'b011,
        BRANCH  = 3'b100
    } imm_src_e;

    // Rotate right within 32 bits; a zero amount returns the value unchanged.
    function automatic logic [IMM_W-1:0] ror32(input logic [IMM_W-1:0] v,
                                              input logic [4:0]       sh);
        return IMM_W'({v, v} >> sh);
    endfunction

endpackage

// File: rtl/ext_stage.sv
// One elastic register stage: valid/ready handshake with a W-bit payload.
module ext_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Empty or draining this cycle: the register can take a new word.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/ext_imm_pipe.sv
// Pipelined ARM immediate extender with valid/ready flow control.
// Optional macro IMM_CARRY_EN adds the shifter carry-out path (c_in -> c_out).
module ext_imm_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int INSTR_W     = 24,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [2:0]         ImmSrc,
    input  logic               c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ExtImm,
    output logic               ExtErr,
    output logic               c_out
);

`ifdef IMM_CARRY_EN
    localparam int CW = 1;
`else
    localparam int CW = 0;
`endif
    localparam int FW = DATA_W + 1 + CW;

    logic [DATA_W-1:0] sel_val;
    logic [ROT_W-1:0]  sel_rot;
    logic              sel_err;

    // Form selection; only DP_ROT carries a non-zero rotate amount forward.
    always_comb begin
        sel_val = '0;
        sel_rot = '0;
        sel_err = 1'b0;
        case (ImmSrc)
            DP_IMM8: sel_val = DATA_W'(Instr[7:0]);
            DP_ROT: begin
                sel_val = DATA_W'(Instr[7:0]);
                sel_rot = Instr[ROT_MSB:ROT_LSB];
            end
            MEM12:   sel_val = DATA_W'(Instr[11:0]);
            MEM_H8:  sel_val = DATA_W'({Instr[11:8], Instr[3:0]});
            BRANCH:  sel_val = {{(DATA_W-INSTR_W-2){Instr[INSTR_W-1]}}, Instr, 2'b00};
            default: sel_err = 1'b1;
        endcase
    end

    logic [DATA_W-1:0] f_val_i, f_val;
    logic [ROT_W-1:0]  f_rot_i;
    logic              f_err_i, f_c_i, f_c;
    logic              f_valid, f_ready;
    logic [IMM_W-1:0]  rot32;

    // Rotation step; non-rotated forms pass through untouched (keeps branch sign bits).
    always_comb begin
        rot32 = ror32(f_val_i[IMM_W-1:0], {f_rot_i, 1'b0});
        f_val = f_val_i;
        f_c   = f_c_i;
        if (f_rot_i != '0) begin
            f_val = DATA_W'(rot32);
            f_c   = rot32[IMM_W-1];
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_two
            localparam int PW = DATA_W + ROT_W + 1 + CW;
            logic [PW-1:0] s1_d, s1_q;

`ifdef IMM_CARRY_EN
            assign s1_d  = {c_in, sel_err, sel_rot, sel_val};
            assign f_c_i = s1_q[PW-1];
`else
            assign s1_d  = {sel_err, sel_rot, sel_val};
            assign f_c_i = 1'b0;
`endif
            assign f_val_i = s1_q[DATA_W-1:0];
            assign f_rot_i = s1_q[DATA_W+ROT_W-1:DATA_W];
            assign f_err_i = s1_q[DATA_W+ROT_W];

            ext_stage #(.W(PW)) u_s1 (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (s1_d),
                .out_valid (f_valid),
                .out_ready (f_ready),
                .out_data  (s1_q)
            );
        end else begin : g_one
            assign f_valid  = in_valid;
            assign in_ready = f_ready;
            assign f_val_i  = sel_val;
            assign f_rot_i  = sel_rot;
            assign f_err_i  = sel_err;
`ifdef IMM_CARRY_EN
            assign f_c_i    = c_in;
`else
            assign f_c_i    = 1'b0;
`endif
        end
    endgenerate

    logic [FW-1:0] fin_d, fin_q;

`ifdef IMM_CARRY_EN
    assign fin_d = {f_c, f_err_i, f_val};
    assign c_out = fin_q[DATA_W+1];
`else
    logic unused_carry;
    assign unused_carry = ^{c_in, f_c};
    assign fin_d = {f_err_i, f_val};
    assign c_out = 1'b0;
`endif

    ext_stage #(.W(FW)) u_out (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (f_valid),
        .in_ready  (f_ready),
        .in_data   (fin_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fin_q)
    );

    assign ExtImm = fin_q[DATA_W-1:0];
    assign ExtErr = fin_q[DATA_W];

endmodule

// File: tb/tb_ext_imm_pipe.sv
// Directed self-checking bench for ext_imm_pipe (DATA_W=64, two stages).
module tb_ext_imm_pipe;

`ifdef IMM_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] Instr;
    logic [2:0]  ImmSrc;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ExtImm;
    logic        ExtErr;
    logic        c_out;

    int checks = 0;
    int errors = 0;

    ext_imm_pipe #(.DATA_W(64), .INSTR_W(24), .PIPE_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Instr     (Instr),
        .ImmSrc    (ImmSrc),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ExtImm    (ExtImm),
        .ExtErr    (ExtErr),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one item (caller is just after a posedge) and wait, bounded, for its transfer.
    task automatic push(input string tag, input logic [2:0] s, input logic [23:0] i, input logic c);
        int n;
        n = 0;
        in_valid = 1'b1; ImmSrc = s; Instr = i; c_in = c;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; Instr = 24'hDEAD5A; ImmSrc = 3'b110; c_in = ~c;
    endtask

    // Single transfer with out_ready high: nothing one cycle after accept, result after two.
    task automatic single(input string tag, input logic [2:0] s, input logic [23:0] i,
                          input logic c, input logic [63:0] e_imm, input logic e_err,
                          input logic e_c);
        push(tag, s, i, c);
        @(negedge clk);
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_imm"}, ExtImm, e_imm);
        chk({tag, "_err"}, 64'(ExtErr), 64'(e_err));
        chk({tag, "_c"}, 64'(c_out), 64'(e_c));
        @(posedge clk); #1;
    endtask

    logic [7:0] got_q[$];
    int         idx;
    bit         acc;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Instr = '0; ImmSrc = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", ExtImm, 64'd0);
        chk("rst_err", 64'(ExtErr), 64'd0);
        chk("rst_c", 64'(c_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle inputs must be ignored.
        Instr = 24'h0004FF; ImmSrc = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        single("rot4",    3'b001, 24'h0004FF, 1'b0, 64'h00000000FF000000, 1'b0, CARRY);
        single("rot1",    3'b001, 24'h000103, 1'b0, 64'h00000000C0000000, 1'b0, CARRY);
        single("rot15",   3'b001, 24'h000F02, 1'b1, 64'h0000000000000008, 1'b0, 1'b0);
        single("rot0",    3'b001, 24'h000081, 1'b1, 64'h0000000000000081, 1'b0, CARRY);
        single("br_neg",  3'b100, 24'hFFFFFE, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0);
        single("br_pos",  3'b100, 24'h000010, 1'b1, 64'h0000000000000040, 1'b0, CARRY);
        single("memh8",   3'b011, 24'h123A05, 1'b0, 64'h00000000000000A5, 1'b0, 1'b0);
        single("mem12",   3'b010, 24'hABCFFF, 1'b0, 64'h0000000000000FFF, 1'b0, 1'b0);
        single("bad7",    3'b111, 24'h0004FF, 1'b0, 64'h0000000000000000, 1'b1, 1'b0);
        single("imm8",    3'b000, 24'h000F7F, 1'b0, 64'h000000000000007F, 1'b0, 1'b0);
        single("bad5",    3'b101, 24'hFFFFFF, 1'b1, 64'h0000000000000000, 1'b1, CARRY);

        // Backpressure: five back-to-back items with the consumer stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; ImmSrc = 3'b000; Instr = 24'h000011; c_in = 1'b0;
        @(negedge clk);
        chk("bp_rdy0", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        Instr = 24'h000012;
        @(negedge clk);
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        Instr = 24'h000013;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stall_rdy", 64'(in_ready), 64'd0);
            chk("bp_stall_valid", 64'(out_valid), 64'd1);
            chk("bp_stall_imm", ExtImm, 64'h11);
            chk("bp_stall_err", 64'(ExtErr), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idx = 2;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (out_valid) got_q.push_back(ExtImm[7:0]);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 5) Instr = 24'(8'h11 + idx);
                else in_valid = 1'b0;
            end
        end
        chk("bp_count", 64'(got_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) chk("bp_order", 64'(got_q[k]), 64'(8'h11 + k));
        end

        // Reset with two items in flight.
        in_valid = 1'b1; ImmSrc = 3'b000; Instr = 24'h000021;
        @(posedge clk); #1;
        Instr = 24'h000022;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_imm", ExtImm, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_flush", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        single("post_rst", 3'b001, 24'h000081, 1'b1, 64'h0000000000000081, 1'b0, CARRY);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
